// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: one word per valid/ready handshake, LSB first,
// configurable data width, parity and stop bits, exact integer baud divisor.
module uart_tx_gen #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
      $error("uart_tx_gen: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit;
  logic                 tx_nxt, done_nxt;
  logic                 wrap, accept;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) return ~(^d);
    else if (PARITY == 2) return ^d;
    else return 1'b0;
  endfunction

  assign wrap   = (baud_cnt == BAUD_LAST);
  assign accept = tx_valid && tx_ready;

  // State register: control is reset, the line idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
    if (accept) par_bit <= parity_of(tx_data);
  end

  // Next-state logic; bit_cnt counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    unique case (state)
      S_IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (accept) begin
          state_nxt = S_START;
          shift_nxt = tx_data;
        end
      end
      S_START: if (wrap) state_nxt = S_DATA;
      S_DATA: begin
        if (wrap) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: if (wrap) state_nxt = S_STOP;
      S_STOP: begin
        if (wrap) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE) baud_nxt = wrap ? '0 : baud_cnt + 1'b1;
  end

  // Outputs; tx is registered from the bit the next state will drive
  always_comb begin
    tx_ready = (state == S_IDLE) && !rst;
    tx_busy  = (state != S_IDLE);
    done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
    unique case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: four instances (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=56,
// expected line bits queued when a word is driven and checked cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_gen;

  localparam int BD = 56;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic [7:0] data8 [3];
  logic [6:0] data7;
  wire  [3:0] ready_w, txl, busy_w, done_w;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_gen #(.CLK_FREQ(560), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data8[0]), .tx_ready(ready_w[0]),
    .tx(txl[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_gen #(.CLK_FREQ(560), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data8[1]), .tx_ready(ready_w[1]),
    .tx(txl[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_gen #(.CLK_FREQ(560), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data8[2]), .tx_ready(ready_w[2]),
    .tx(txl[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_gen #(.CLK_FREQ(560), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data7), .tx_ready(ready_w[3]),
    .tx(txl[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  function automatic int db_of(int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int sb_of(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(int i, logic [7:0] w);
    if (i == 3) data7 = w[6:0];
    else data8[i] = w;
  endtask

  // Present a word and queue the line bits the frame must carry
  task automatic drive(int i, logic [7:0] w);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int j = 0; j < db_of(i); j++) begin
      exp_q.push_back(w[j]);
      p = p ^ w[j];
    end
    if (par_of(i) == 1) exp_q.push_back(~p);
    else if (par_of(i) == 2) exp_q.push_back(p);
    for (int j = 0; j < sb_of(i); j++) exp_q.push_back(1'b1);
    set_data(i, w);
    valid[i] = 1'b1;
  endtask

  // Wait for acceptance, then check every cycle of the frame against the queue
  task automatic frame(int i, bit hold, int pulse_cyc, string tag);
    int   t, cyc, idx, bad_tx, bad_st;
    logic b;
    t = 0;
    while (!ready_w[i] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_accept"}, 32'(ready_w[i]), 1);
    @(negedge clk);
    if (!hold) valid[i] = 1'b0;
    cyc = 0;
    idx = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      bad_tx = 0;
      bad_st = 0;
      for (int k = 0; k < BD; k++) begin
        if (cyc == pulse_cyc) begin
          set_data(i, 8'h3C);
          valid[i] = 1'b1;
        end else if (pulse_cyc >= 0 && cyc == pulse_cyc + 1) begin
          valid[i] = 1'b0;
        end
        if (txl[i] !== b) bad_tx++;
        if ({busy_w[i], ready_w[i], done_w[i]} !== 3'b100) bad_st++;
        cyc++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d_tx_bad_cycles", tag, idx), bad_tx, 0);
      chk($sformatf("%s_bit%0d_status_bad_cycles", tag, idx), bad_st, 0);
      idx++;
    end
    chk({tag, "_done"}, 32'(done_w[i]), 1);
    chk({tag, "_done_tx"}, 32'(txl[i]), 1);
    chk({tag, "_done_ready"}, 32'(ready_w[i]), 1);
    chk({tag, "_done_busy"}, 32'(busy_w[i]), 0);
  endtask

  task automatic idle_check(int i, int n, string tag);
    int bad;
    bad = 0;
    valid[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (txl[i] !== 1'b1 || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 || ready_w[i] !== 1'b1)
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = 4'b0;
    data7 = '0;
    for (int i = 0; i < 3; i++) data8[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(txl), 32'hF);
    chk("reset_busy", 32'(busy_w), 0);
    chk("reset_done", 32'(done_w), 0);
    chk("reset_ready", 32'(ready_w), 0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(ready_w), 32'hF);
    @(negedge clk);

    // 8N1 with 8'hA5
    drive(0, 8'hA5);
    frame(0, 1'b0, -1, "t1_8n1_a5");
    idle_check(0, 20, "t1_idle_after");

    // Even and odd parity on 8'h07
    drive(1, 8'h07);
    frame(1, 1'b0, -1, "t2_8e1_07");
    idle_check(1, 10, "t2e_idle_after");
    drive(2, 8'h07);
    frame(2, 1'b0, -1, "t2_8o1_07");
    idle_check(2, 10, "t2o_idle_after");

    // 7 data bits, two stop bits
    drive(3, 8'h41);
    frame(3, 1'b0, -1, "t3_7n2_41");
    idle_check(3, 10, "t3_idle_after");

    // Back-to-back frames with tx_valid held high
    drive(0, 8'h12);
    frame(0, 1'b1, -1, "t4_w0");
    drive(0, 8'h34);
    frame(0, 1'b1, -1, "t4_w1");
    drive(0, 8'hC3);
    frame(0, 1'b0, -1, "t4_w2");
    idle_check(0, 20, "t4_idle_after");

    // Reset in the middle of data bit 3 (bit 3 of 8'h35 is 0)
    drive(0, 8'h35);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (4 * BD + BD / 2) @(negedge clk);
    chk("t5_line_low_in_bit3", 32'(txl[0]), 0);
    chk("t5_busy_in_bit3", 32'(busy_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_tx", 32'(txl[0]), 1);
    chk("t5_rst_busy", 32'(busy_w[0]), 0);
    chk("t5_rst_done", 32'(done_w[0]), 0);
    chk("t5_rst_ready", 32'(ready_w[0]), 0);
    exp_q.delete();
    rst = 1'b0;
    idle_check(0, 700, "t5_no_done_after_abort");
    drive(0, 8'h5A);
    frame(0, 1'b0, -1, "t5_next_word");
    idle_check(0, 20, "t5_idle_after");

    // tx_valid pulsed while busy must be ignored
    drive(0, 8'h96);
    frame(0, 1'b0, 300, "t6_pulse_busy");
    idle_check(0, 200, "t6_no_extra_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
